// File: rtl/vga_fb_arbiter.sv
// Frame-buffer SRAM arbiter: one display read per 2-clock pixel in active
// video, every remaining slot handed to the writer via req/ack.
module vga_fb_arbiter #(
    parameter int H_PIXELS = 640,
    parameter int V_PIXELS = 480,
    parameter int ADDR_W   = 19,
    parameter int DATA_W   = 8
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              blank,
    input  logic [8:0]        row,
    input  logic [9:0]        col,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic              wr_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] pixel,
    output logic              pixel_valid
);

    localparam logic [ADDR_W-1:0] FB_SIZE = ADDR_W'(H_PIXELS * V_PIXELS);
    localparam logic [ADDR_W-1:0] STRIDE  = ADDR_W'(H_PIXELS);

    logic              p;
    logic [1:0]        pend;
    logic [1:0]        blank_d;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_slot;
    logic              wr_slot;
    logic              wr_ok;

    assign disp_addr = ADDR_W'(row) * STRIDE + ADDR_W'(col);
    assign disp_slot = !blank && !p;
    assign wr_slot   = wr_req && !wr_ack;
    assign wr_ok     = wr_addr < FB_SIZE;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            p         <= 1'b0;
            pend      <= '0;
            blank_d   <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            wr_ack    <= 1'b0;
            wr_err    <= 1'b0;
        end else begin
            p       <= blank ? 1'b0 : ~p;
            pend    <= {pend[0], disp_slot};
            blank_d <= {blank_d[0], blank};
            // Display read always wins; a pending write slips to the p=1 clock
            if (disp_slot) begin
                mem_addr <= disp_addr;
                mem_we   <= 1'b0;
                wr_ack   <= 1'b0;
            end else if (wr_slot) begin
                wr_ack <= 1'b1;
                if (wr_ok) begin
                    mem_addr  <= wr_addr;
                    mem_wdata <= wr_data;
                    mem_we    <= 1'b1;
                end else begin
                    mem_we <= 1'b0;
                    wr_err <= 1'b1;
                end
            end else begin
                mem_we <= 1'b0;
                wr_ack <= 1'b0;
            end
        end
    end

    // Blank delayed two clocks so the last fetched pixel still shows for its full period
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            pixel       <= '0;
            pixel_valid <= 1'b0;
        end else if (pend[1]) begin
            pixel       <= mem_rdata;
            pixel_valid <= 1'b1;
        end else if (blank_d == 2'b11) begin
            pixel       <= '0;
            pixel_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Scoreboard bench for vga_fb_arbiter: stimulus pushes expectations,
// a negedge monitor pops and compares against DUT outputs.
module tb_vga_fb_arbiter;

    localparam logic [18:0] FB = 19'd307200;

    typedef struct { int due; logic [18:0] addr; } rd_t;
    typedef struct { int due; logic [7:0] val; } pix_t;
    typedef struct { logic [18:0] addr; logic [7:0] data; logic ok; } wr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        blank = 1'b1;
    logic [8:0]  row = '0;
    logic [9:0]  col = '0;
    logic        wr_req = 1'b0;
    logic [18:0] wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic        wr_ack;
    logic        wr_err;
    logic [18:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_rdata = '0;
    logic [7:0]  pixel;
    logic        pixel_valid;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int ack_cnt = 0;
    logic prev_ack = 1'b0;

    rd_t  rq[$];
    pix_t pq[$];
    wr_t  wq[$];

    logic [7:0] sram [0:524287];
    bit         wrt  [0:524287];
    logic [7:0] ref_mem [0:524287];

    vga_fb_arbiter dut (
        .CLOCK_50    (clk),
        .reset       (reset),
        .blank       (blank),
        .row         (row),
        .col         (col),
        .wr_req      (wr_req),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_ack      (wr_ack),
        .wr_err      (wr_err),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .mem_rdata   (mem_rdata),
        .pixel       (pixel),
        .pixel_valid (pixel_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM: unwritten locations read back as their address low byte
    always @(posedge clk) begin
        if (mem_we) begin
            sram[mem_addr] <= mem_wdata;
            wrt[mem_addr]  <= 1'b1;
        end
        mem_rdata <= wrt[mem_addr] ? sram[mem_addr] : mem_addr[7:0];
    end

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic void fail(string nm);
        total++;
        bad++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endfunction

    always @(negedge clk) begin
        rd_t  r;
        pix_t q;
        wr_t  w;
        while (rq.size() > 0 && rq[0].due < cyc) begin
            fail("display read missed");
            void'(rq.pop_front());
        end
        if (rq.size() > 0 && rq[0].due == cyc) begin
            r = rq.pop_front();
            chk("rd_addr", 64'(mem_addr), 64'(r.addr));
            chk("rd_we", 64'(mem_we), 64'd0);
        end
        while (pq.size() > 0 && pq[0].due < cyc) begin
            fail("pixel missed");
            void'(pq.pop_front());
        end
        if (pq.size() > 0 && pq[0].due == cyc) begin
            q = pq.pop_front();
            chk("pixel", 64'(pixel), 64'(q.val));
            chk("pixel_valid", 64'(pixel_valid), 64'd1);
        end
        if (wr_ack) begin
            ack_cnt++;
            chk("ack_gap", 64'(prev_ack), 64'd0);
            if (wq.size() == 0) begin
                fail("unexpected wr_ack");
            end else begin
                w = wq.pop_front();
                if (w.ok) begin
                    chk("wr_we", 64'(mem_we), 64'd1);
                    chk("wr_addr", 64'(mem_addr), 64'(w.addr));
                    chk("wr_data", 64'(mem_wdata), 64'(w.data));
                end else begin
                    chk("oor_we", 64'(mem_we), 64'd0);
                    chk("oor_err", 64'(wr_err), 64'd1);
                end
            end
        end
        if (mem_we) chk("we_without_ack", 64'(wr_ack), 64'd1);
        prev_ack <= wr_ack;
    end

    task automatic write_one(input logic [18:0] a, input logic [7:0] d, output int lat);
        int k;
        int t0;
        t0 = cyc;
        wr_addr = a;
        wr_data = d;
        wr_req  = 1'b1;
        wq.push_back('{a, d, a < FB});
        if (a < FB) ref_mem[a] = d;
        k = 0;
        @(negedge clk);
        while (!wr_ack && k < 40) begin
            @(negedge clk);
            k++;
        end
        lat = cyc - t0;
        if (!wr_ack) begin
            fail("write ack timeout");
            if (wq.size() > 0) void'(wq.pop_back());
        end
    endtask

    task automatic scan(input int r, input int c0, input int n);
        logic [18:0] a;
        for (int i = 0; i < n; i++) begin
            a = 19'(r * 640 + c0 + i);
            blank = 1'b0;
            row = 9'(r);
            col = 10'(c0 + i);
            rq.push_back('{cyc + 1, a});
            pq.push_back('{cyc + 3, ref_mem[a]});
            pq.push_back('{cyc + 4, ref_mem[a]});
            @(negedge clk);
            @(negedge clk);
        end
        blank = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_blanked();
        idle(4);
        chk("blank_pixel_valid", 64'(pixel_valid), 64'd0);
        chk("blank_pixel", 64'(pixel), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int a0;
        for (int i = 0; i < 524288; i++) ref_mem[i] = 8'(i);

        // reset with toggling inputs
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            blank   = 1'($urandom_range(0, 1));
            row     = 9'($urandom_range(0, 479));
            col     = 10'($urandom_range(0, 639));
            wr_req  = 1'($urandom_range(0, 1));
            wr_addr = 19'($urandom_range(0, 307199));
            wr_data = 8'($urandom_range(0, 255));
            chk("reset_outs", {mem_addr, mem_wdata, mem_we, wr_ack, wr_err, pixel, pixel_valid}, 64'd0);
        end
        @(negedge clk);
        blank = 1'b1;
        wr_req = 1'b0;
        reset = 1'b0;
        idle(2);
        chk("post_reset_we", 64'(mem_we), 64'd0);
        chk("post_reset_pv", 64'(pixel_valid), 64'd0);

        // blanking writes, streamed back to back
        a0 = ack_cnt;
        for (int i = 0; i < 4; i++) begin
            write_one(19'(i), 8'(8'hA0 + i), lat);
            chk("blank_lat", 64'(lat), (i == 0) ? 64'd1 : 64'd2);
        end
        wr_req = 1'b0;
        idle(3);
        chk("blank_ack_count", 64'(ack_cnt - a0), 64'd4);

        // scanout of preloaded row 2, then row 0 holding the new writes
        scan(2, 0, 4);
        check_blanked();
        scan(0, 0, 4);
        check_blanked();

        // contention: writer streams for the whole active span
        a0 = ack_cnt;
        fork
            scan(50, 100, 12);
            begin
                for (int i = 0; i < 12; i++) begin
                    write_one(19'($urandom_range(100000, 307199)), 8'($urandom_range(0, 255)), lat);
                    chk("cont_lat", 64'(lat), 64'd2);
                end
                wr_req = 1'b0;
            end
        join
        check_blanked();
        chk("cont_ack_count", 64'(ack_cnt - a0), 64'd12);
        chk("err_clear", 64'(wr_err), 64'd0);

        // random scans
        for (int k = 0; k < 3; k++) begin
            scan($urandom_range(3, 99), $urandom_range(0, 630), 5);
            idle(2);
        end
        check_blanked();

        // out-of-range writes and sticky error
        write_one(FB, 8'h11, lat);
        wr_req = 1'b0;
        chk("oor_lat", 64'(lat), 64'd1);
        idle(2);
        chk("err_sticky", 64'(wr_err), 64'd1);
        write_one(19'($urandom_range(307201, 524287)), 8'h22, lat);
        write_one(19'd307199, 8'h5C, lat);
        wr_req = 1'b0;
        idle(3);
        chk("err_sticky2", 64'(wr_err), 64'd1);

        // last frame-buffer location
        scan(479, 636, 4);
        check_blanked();
        chk("err_sticky3", 64'(wr_err), 64'd1);

        // reset mid-request
        wr_addr = 19'd5000;
        wr_data = 8'h5A;
        wr_req  = 1'b1;
        #1 reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_no_ack", 64'(wr_ack), 64'd0);
            chk("rst_no_we", 64'(mem_we), 64'd0);
        end
        reset = 1'b0;
        a0 = ack_cnt;
        write_one(19'd5000, 8'h5A, lat);
        wr_req = 1'b0;
        chk("rst_retry_lat", 64'(lat), 64'd1);
        idle(4);
        chk("rst_retry_acks", 64'(ack_cnt - a0), 64'd1);
        chk("rst_err_cleared", 64'(wr_err), 64'd0);
        scan(7, 519, 3);
        check_blanked();

        idle(5);
        chk("rd_q_empty", 64'(rq.size()), 64'd0);
        chk("pix_q_empty", 64'(pq.size()), 64'd0);
        chk("wr_q_empty", 64'(wq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
